// File: rtl/shifter_pkg.sv
// -----------------------------------------------------------------------------
// shifter_pkg
// Shared types for the iterative shifter.
//   shift_mode_t : 3-bit operation code (pass / LSL / LSR / ASR / ROR)
//   iter_state_t : controller states (IDLE / SHIFT / DONE)
//   mode_shifts  : true when a mode code moves bits (pass-like codes return 0)
// Build option: ITER_SHIFTER_ROTATE_EN enables ROR for mode 100; when it is
// undefined, 100 is treated as pass.
// -----------------------------------------------------------------------------
package shifter_pkg;

    typedef enum logic [2:0] {
        MODE_PASS = 3'b000,
        MODE_LSL  = 3'b001,
        MODE_LSR  = 3'b010,
        MODE_ASR  = 3'b011,
        MODE_ROR  = 3'b100
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } iter_state_t;

    // Codes 101..111 (and 100 without rotate support) fall through to pass.
    function automatic logic mode_shifts(input logic [2:0] m);
        logic r;
        r = 1'b0;
        case (m)
            MODE_LSL, MODE_LSR, MODE_ASR: r = 1'b1;
`ifdef ITER_SHIFTER_ROTATE_EN
            MODE_ROR:                     r = 1'b1;
`endif
            default:                      r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/shift_step.sv
// -----------------------------------------------------------------------------
// shift_step
// Combinational single-bit step of the iterative shifter.
//   w_in  : current working value
//   mode  : operation code (shift_mode_t encoding)
//   w_out : w_in moved by exactly one bit position (or unchanged for pass)
// Build option: ITER_SHIFTER_ROTATE_EN adds the ROR step; without it no
// rotate path exists and mode 100 passes the value through.
// -----------------------------------------------------------------------------
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] w_in,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] w_out
);

    always_comb begin
        w_out = w_in;
        case (mode)
            MODE_LSL: w_out = {w_in[WIDTH-2:0], 1'b0};
            MODE_LSR: w_out = {1'b0, w_in[WIDTH-1:1]};
            MODE_ASR: w_out = {w_in[WIDTH-1], w_in[WIDTH-1:1]};
`ifdef ITER_SHIFTER_ROTATE_EN
            MODE_ROR: w_out = {w_in[0], w_in[WIDTH-1:1]};
`endif
            default:  w_out = w_in;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// -----------------------------------------------------------------------------
// iter_shifter
// Multi-cycle barrel-shift replacement: one bit per clock through a single
// shift_step instance, controlled by an IDLE/SHIFT/DONE FSM.
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready : request handshake (ready only in IDLE)
//   in_data, mode, amt  : operand, operation code, shift count (captured on accept)
//   out_valid/out_ready : result handshake (valid only in DONE)
//   out_data            : result, forced to 0 outside DONE
//   busy                : high whenever the FSM is not IDLE
// Build option: ITER_SHIFTER_ROTATE_EN enables ROR on mode 100.
// -----------------------------------------------------------------------------
module iter_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    iter_state_t      state, state_nxt;
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] w_step;
    logic [AMT_W-1:0] cnt;
    logic [2:0]       md;
    logic             accept;

    assign accept = (state == IDLE) && in_valid;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .w_in  (w),
        .mode  (md),
        .w_out (w_step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        out_data  = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    // Zero count or pass-like mode skips straight to the result.
                    if ((amt != '0) && mode_shifts(mode)) state_nxt = SHIFT;
                    else                                  state_nxt = DONE;
                end
            end
            SHIFT: begin
                // The step taken in this cycle is the last one when cnt is 1.
                if (cnt == AMT_W'(1)) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                out_data  = w;
                // Return to IDLE only; a new request waits for the next cycle.
                if (out_ready) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w   <= '0;
            cnt <= '0;
            md  <= MODE_PASS;
        end else if (accept) begin
            w   <= in_data;
            cnt <= amt;
            md  <= mode;
        end else if (state == SHIFT) begin
            w   <= w_step;
            cnt <= cnt - AMT_W'(1);
        end
    end

endmodule

// File: tb/tb_iter_shifter.sv
module tb_iter_shifter;

    localparam int W = 16;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [2:0]    mode;
    logic [3:0]    amt;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          busy;

    iter_shifter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mode      (mode),
        .amt       (amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  m;
        logic [15:0] d;
        logic [3:0]  a;
        logic [15:0] e;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] e;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

`ifdef ITER_SHIFTER_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference result computed from whole-word operators, not bit stepping.
    function automatic logic [15:0] model(input logic [2:0] m, input logic [15:0] d, input logic [3:0] a);
        logic signed [15:0] s;
        logic [31:0]        dd;
        s  = d;
        dd = {d, d} >> a;
        case (m)
            3'b001:  return d << a;
            3'b010:  return d >> a;
            3'b011:  return s >>> a;
            3'b100:  return ROT ? dd[15:0] : d;
            default: return d;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] m, input logic [3:0] a);
        bit moves;
        moves = (m == 3'b001) || (m == 3'b010) || (m == 3'b011) || (ROT && m == 3'b100);
        return (moves && a != 0) ? int'(a) + 1 : 1;
    endfunction

    // One transaction: drive at a falling edge, scramble inputs while busy,
    // pop the scoreboard when out_valid appears, optionally stall out_ready.
    task automatic run_txn(input logic [2:0] m, input logic [15:0] d, input logic [3:0] a,
                           input logic [15:0] e, input int lat, input int hold, input string tag);
        int          k;
        bit          got;
        exp_t        x;
        logic [15:0] held;
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1; in_data = d; mode = m; amt = a;
        sb.push_back('{e: e, lat: lat});
        got = 0; k = 0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            in_valid = (hold > 0);
            in_data  = 16'($urandom);
            mode     = 3'($urandom);
            amt      = 4'($urandom);
            if (out_valid) got = 1;
        end
        if (!got) begin
            check({tag, "_timeout"}, 0, 1);
            sb.delete();
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            in_valid = 1'b0;
            return;
        end
        x = sb.pop_front();
        check({tag, "_latency"}, k, x.lat);
        check({tag, "_data"}, out_data, x.e);
        held = out_data;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_data"}, out_data, held);
            check({tag, "_hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_post_in_ready"}, in_ready, 1);
        check({tag, "_post_out_valid"}, out_valid, 0);
        check({tag, "_post_out_data"}, out_data, 0);
        in_valid = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{m: 3'b001, d: 16'h8001, a: 4'd3,  e: 16'h0008, lat: 4};
        vecs[1] = '{m: 3'b011, d: 16'h8000, a: 4'd15, e: 16'hFFFF, lat: 16};
        vecs[2] = '{m: 3'b010, d: 16'h8000, a: 4'd15, e: 16'h0001, lat: 16};
        vecs[3] = '{m: 3'b000, d: 16'h1234, a: 4'd7,  e: 16'h1234, lat: 1};
        vecs[4] = '{m: 3'b001, d: 16'h1234, a: 4'd0,  e: 16'h1234, lat: 1};
        vecs[5] = '{m: 3'b100, d: 16'h0001, a: 4'd1,  e: ROT ? 16'h8000 : 16'h0001, lat: ROT ? 2 : 1};
        vecs[6] = '{m: 3'b111, d: 16'hABCD, a: 4'd5,  e: 16'hABCD, lat: 1};
        vecs[7] = '{m: 3'b101, d: 16'h00F0, a: 4'd9,  e: 16'h00F0, lat: 1};
        vecs[8] = '{m: 3'b011, d: 16'h4000, a: 4'd2,  e: 16'h1000, lat: 3};
        vecs[9] = '{m: 3'b010, d: 16'hF00F, a: 4'd4,  e: 16'h0F00, lat: 5};

        reset = 1'b1; in_valid = 1'b0; in_data = '0; mode = '0; amt = '0; out_ready = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i])
            run_txn(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].e, vecs[i].lat, 0, $sformatf("vec%0d", i));

        // Stalled consumer with in_valid held high throughout DONE.
        run_txn(3'b001, 16'h00FF, 4'd4, 16'h0FF0, 5, 5, "stall");

        for (int r = 0; r < 8; r++) begin
            logic [2:0]  m;
            logic [15:0] d;
            logic [3:0]  a;
            m = 3'($urandom_range(0, 7));
            d = 16'($urandom);
            a = 4'($urandom_range(0, 15));
            run_txn(m, d, a, model(m, d, a), model_lat(m, a), r % 2, $sformatf("rnd%0d", r));
        end

        // Reset in the middle of a long ASR; the pending result must vanish.
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h8000; mode = 3'b011; amt = 4'd10;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy_before", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (out_valid || busy) seen++;
            end
            check("mid_rst_no_stale", seen, 0);
            check("mid_rst_ready_after", in_ready, 1);
        end

        // Engine still usable after the interrupted transaction.
        run_txn(3'b011, 16'h8000, 4'd3, 16'hF000, 4, 0, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
